// File: rtl/rd_arb_controller.sv
// rd_arb_controller: round-robin arbiter granting FIFO read channels.
// Each grant runs up to burst_len words. A word is one valid handshake (HS),
// then a single-cycle load strobe (READ). An optional HOLD gap sits between words.
// All outputs are Moore: decoded from the state and grant registers only.
module rd_arb_controller #(
    parameter int NCH       = 4,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 8,
    localparam int IDW      = $clog2(NCH),
    localparam int BLW      = $clog2(BURST_MAX + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] read_en,
    input  logic [NCH-1:0] empty,
    input  logic [BLW-1:0] burst_len,
    output logic [NCH-1:0] valid,
    output logic [NCH-1:0] ld,
    output logic [IDW-1:0] grant_id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HS   = 2'd1,
        READ = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] grant_reg, grant_next;
    logic [IDW-1:0] last_grant_reg, last_grant_next;
    logic [BLW-1:0] word_cnt_reg, word_cnt_next;
    logic [7:0]     tmo_cnt_reg, tmo_cnt_next;

    logic [NCH-1:0] eligible;
    logic [NCH-1:0] grant_onehot;
    logic           sel_found;
    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] cand;
    logic [BLW-1:0] burst_clamped;

    assign eligible = read_en & ~empty;

    // One-hot decode of the registered grant, shared by valid and ld
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_reg == IDW'(gi));
        end
    endgenerate

    // Round-robin search starting just after the last served channel.
    // The candidate index wraps explicitly, so NCH need not be a power of two.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_grant_reg;
        for (int k = 0; k < NCH; k++) begin
            if (cand == IDW'(NCH - 1)) begin
                cand = '0;
            end else begin
                cand = cand + IDW'(1);
            end
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Requested burst length is forced into 1..BURST_MAX
    always_comb begin
        if (burst_len == '0) begin
            burst_clamped = BLW'(1);
        end else if (burst_len > BLW'(BURST_MAX)) begin
            burst_clamped = BLW'(BURST_MAX);
        end else begin
            burst_clamped = burst_len;
        end
    end

    // Next-state logic for the arbitration / burst sequencing FSM
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        word_cnt_next   = word_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next    = HS;
                    grant_next    = sel_idx;
                    word_cnt_next = burst_clamped;
                end
            end
            HS: begin
                // The word is already committed here, so empty is ignored
                if (!read_en[grant_reg]) begin
                    state_next = READ;
                end
            end
            READ: begin
                word_cnt_next = word_cnt_reg - BLW'(1);
                if (word_cnt_reg == BLW'(1) || empty[grant_reg]) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end else begin
                    state_next   = HOLD;
                    tmo_cnt_next = '0;
                end
            end
            HOLD: begin
                tmo_cnt_next = tmo_cnt_reg + 8'd1;
                if (empty[grant_reg]) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end else if (read_en[grant_reg]) begin
                    state_next = HS;
                end else if (tmo_cnt_reg == 8'(TIMEOUT - 1)) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset lands so channel 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDW'(NCH - 1);
            word_cnt_reg   <= '0;
            tmo_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            word_cnt_reg   <= word_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    assign valid    = (state_reg == HS)   ? grant_onehot : '0;
    assign ld       = (state_reg == READ) ? grant_onehot : '0;
    assign busy     = (state_reg != IDLE);
    assign grant_id = grant_reg;

endmodule

// File: tb/tb_rd_arb_controller.sv
// Testbench for rd_arb_controller. It combines directed scenarios with
// randomized traffic, and compares every cycle against a transaction-level
// model of the arbitration rules.
module tb_rd_arb_controller;

    localparam int NCH       = 4;
    localparam int BURST_MAX = 4;
    localparam int TIMEOUT   = 8;

    localparam int PH_HANDSHAKE = 0;
    localparam int PH_LOAD      = 1;
    localparam int PH_GAP       = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] read_en;
    logic [3:0] empty;
    logic [2:0] burst_len;
    logic [3:0] valid;
    logic [3:0] ld;
    logic [1:0] grant_id;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner < 0 means no channel holds the grant
    int owner;
    int phase;
    int words_left;
    int gap_cycles;
    int prev_owner;
    int shown_id;

    int ld_total = 0;
    int ld_ch[NCH];

    always #5 clk = ~clk;

    rd_arb_controller #(
        .NCH      (NCH),
        .BURST_MAX(BURST_MAX),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .read_en  (read_en),
        .empty    (empty),
        .burst_len(burst_len),
        .valid    (valid),
        .ld       (ld),
        .grant_id (grant_id),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        owner      = -1;
        phase      = PH_HANDSHAKE;
        words_left = 0;
        gap_cycles = 0;
        prev_owner = NCH - 1;
        shown_id   = 0;
    endfunction

    function automatic void model_release();
        prev_owner = owner;
        owner      = -1;
    endfunction

    // Advance the model by one clock using the inputs present at the edge
    function automatic void model_step();
        int c;
        int want;
        if (owner < 0) begin
            for (int k = 1; k <= NCH; k++) begin
                c = (prev_owner + k) % NCH;
                if (owner < 0 && read_en[c] && !empty[c]) begin
                    owner    = c;
                    shown_id = c;
                    phase    = PH_HANDSHAKE;
                    want     = int'(burst_len);
                    if (want == 0) want = 1;
                    if (want > BURST_MAX) want = BURST_MAX;
                    words_left = want;
                end
            end
        end else if (phase == PH_HANDSHAKE) begin
            if (!read_en[owner]) phase = PH_LOAD;
        end else if (phase == PH_LOAD) begin
            words_left = words_left - 1;
            if (words_left == 0 || empty[owner]) begin
                model_release();
            end else begin
                phase      = PH_GAP;
                gap_cycles = 0;
            end
        end else begin
            if (empty[owner]) begin
                model_release();
            end else if (read_en[owner]) begin
                phase = PH_HANDSHAKE;
            end else if (gap_cycles == TIMEOUT - 1) begin
                model_release();
            end else begin
                gap_cycles = gap_cycles + 1;
            end
        end
    endfunction

    task automatic compare_outputs();
        logic [3:0] exp_valid;
        logic [3:0] exp_ld;
        exp_valid = 4'b0000;
        exp_ld    = 4'b0000;
        if (owner >= 0 && phase == PH_HANDSHAKE) exp_valid = 4'b0001 << owner;
        if (owner >= 0 && phase == PH_LOAD)      exp_ld    = 4'b0001 << owner;
        check("valid", valid, exp_valid);
        check("ld", ld, exp_ld);
        check("busy", busy, owner >= 0);
        check("grant_id", grant_id, shown_id);
    endtask

    // One clock: sample #1 after the edge, advance model, compare, log words
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        compare_outputs();
        if (ld != 4'b0000) begin
            ld_total++;
            ld_ch[grant_id]++;
            $display("word: ch=%0d ld=%b t=%0t", grant_id, ld, $time);
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        read_en   = 4'b0000;
        empty     = 4'b0000;
        burst_len = 3'd1;
        #1;
        model_reset();
        compare_outputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock
    task automatic async_reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (valid != 4'b0000) break;
            tick();
        end
        check(tag, {31'b0, valid != 4'b0000}, 1);
    endtask

    // Consumer for one grant on channel ch: drop read_en on valid, re-raise it in the gap
    task automatic run_burst(input int ch, input int bl, input int exp_pulses, input string tag);
        int  start;
        int  since;
        bit  seen;
        bit  done;
        bit  grant_ok;
        start     = ld_ch[ch];
        since     = 99;
        seen      = 1'b0;
        done      = 1'b0;
        grant_ok  = 1'b1;
        burst_len = 3'(bl);
        read_en   = 4'b0001 << ch;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (busy && grant_id != 2'(ch)) grant_ok = 1'b0;
            if (valid[ch]) read_en[ch] = 1'b0;
            if (ld[ch]) begin
                seen  = 1'b1;
                since = 0;
            end else begin
                since++;
            end
            if (seen && !busy) begin
                done    = 1'b1;
                read_en = 4'b0000;
            end else if (since == 1) begin
                read_en[ch] = 1'b1;
            end
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_pulses"}, ld_ch[ch] - start, exp_pulses);
        check({tag, "_grant"}, grant_ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int hold;
        int vcount;
        for (int i = 0; i < NCH; i++) ld_ch[i] = 0;

        // Single word on channel 2
        apply_reset();
        read_en   = 4'b0100;
        burst_len = 3'd1;
        tick();
        check("s1_valid", valid, 4'b0100);
        repeat (3) tick();
        check("s1_valid_held", valid, 4'b0100);
        read_en = 4'b0000;
        tick();
        check("s1_ld", ld, 4'b0100);
        tick();
        check("s1_busy_idle", busy, 0);
        check("s1_ld_single", ld, 4'b0000);

        // Round-robin over all channels, one word each
        apply_reset();
        read_en   = 4'b1111;
        burst_len = 3'd1;
        for (int w = 0; w < 5; w++) begin
            wait_valid("s2_wait_valid");
            check($sformatf("s2_grant%0d", w), grant_id, w % NCH);
            read_en = 4'b0000;
            tick();
            read_en = 4'b1111;
            tick();
        end
        read_en = 4'b0000;
        repeat (4) tick();

        // Bursts on channel 1: nominal, zero length, over-long
        run_burst(1, 3, 3, "s3_bl3");
        run_burst(1, 0, 1, "s3_bl0");
        run_burst(1, 7, 4, "s3_bl7");

        // empty rises during the gap: back to idle, no further word
        burst_len = 3'd3;
        read_en   = 4'b0010;
        wait_valid("s4a_wait_valid");
        read_en = 4'b0000;
        tick();
        tick();
        check("s4a_in_gap", busy, 1);
        empty[1] = 1'b1;
        start    = ld_total;
        tick();
        check("s4a_idle", busy, 0);
        repeat (3) tick();
        check("s4a_no_ld", ld_total - start, 0);
        empty = 4'b0000;

        // Consumer never re-raises: gap lasts TIMEOUT cycles
        burst_len = 3'd3;
        read_en   = 4'b0010;
        wait_valid("s4b_wait_valid");
        read_en = 4'b0000;
        tick();
        hold = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!busy) break;
            hold++;
        end
        check("s4b_gap_cycles", hold, TIMEOUT);

        // Every requester empty: nothing is granted
        empty   = 4'b1111;
        read_en = 4'b1111;
        vcount  = 0;
        repeat (20) begin
            tick();
            if (valid != 4'b0000) vcount++;
        end
        check("s4c_no_valid", vcount, 0);
        check("s4c_not_busy", busy, 0);
        read_en = 4'b0000;
        empty   = 4'b0000;
        tick();

        // Reset during handshake, then arbitration restarts at channel 0
        apply_reset();
        read_en   = 4'b0100;
        burst_len = 3'd2;
        tick();
        check("s5_valid", valid, 4'b0100);
        start = ld_total;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("s5_async_valid", valid, 4'b0000);
        check("s5_async_busy", busy, 0);
        check("s5_async_grant", grant_id, 0);
        tick();
        read_en = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        check("s5_rearb_grant", grant_id, 0);
        check("s5_rearb_valid", valid, 4'b0001);
        check("s5_no_ld", ld_total - start, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < NCH; b++) begin
                if ($urandom_range(0, 3) == 0) read_en[b] = ~read_en[b];
                empty[b] = ($urandom_range(0, 9) == 0);
            end
            burst_len = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) async_reset_pulse();
            else                             tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
